// File: rtl/qupls4_stream_alloc_if.sv
// Handshake bundle between the branch-miss stage, commit/flush free ports and the stream
// allocator.
interface qupls4_stream_alloc_if #(
  parameter int unsigned SW = 7
);
  logic          alloc_i;
  logic [SW-1:0] new_stream;
  logic          new_stream_v;
  logic          free0_i;
  logic [SW-1:0] free0_id;
  logic          free1_i;
  logic [SW-1:0] free1_id;
  logic [7:0]    nfree;
  logic          err_dblfree;
  logic          err_empty;

  modport master (
    output alloc_i, free0_i, free0_id, free1_i, free1_id,
    input  new_stream, new_stream_v, nfree, err_dblfree, err_empty
  );

  modport slave (
    input  alloc_i, free0_i, free0_id, free1_i, free1_id,
    output new_stream, new_stream_v, nfree, err_dblfree, err_empty
  );
endinterface

// File: rtl/qupls4_stream_alloc.sv
// PC stream-ID allocator: free bitmap with a registered pre-selected lowest free ID,
// two free ports and sticky error flags.
module qupls4_stream_alloc #(
  parameter int unsigned NSTREAM = 32,
  parameter int unsigned SW      = 7
) (
  input logic                  clk,
  input logic                  rst_n,
  qupls4_stream_alloc_if.slave sa
);

  // ID 0 is "no stream"; ID 1 is the reset stream, in use out of reset.
  localparam logic [NSTREAM-1:0] MapRst = {{(NSTREAM - 2){1'b1}}, 2'b00};

  logic [NSTREAM-1:0] map_q, map_d;
  logic [SW-1:0]      ns_q, ns_d;
  logic               ns_v_q, ns_v_d;
  logic [7:0]         nfree_q, nfree_d;
  logic               err_dbl_q, err_empty_q;
  logic               alloc_ok, dbl;

  always_comb begin
    alloc_ok = sa.alloc_i & ns_v_q;
    map_d    = map_q;
    dbl      = 1'b0;

    for (int unsigned i = 0; i < NSTREAM; i++) begin
      if (alloc_ok && ns_q == SW'(i)) map_d[i] = 1'b0;
    end

    // Frees are applied after the alloc clear so that a same-cycle free wins.
    for (int unsigned i = 1; i < NSTREAM; i++) begin
      if (sa.free0_i && sa.free0_id == SW'(i)) begin
        if (map_q[i] && !(alloc_ok && ns_q == SW'(i))) dbl = 1'b1;
        map_d[i] = 1'b1;
      end
      if (sa.free1_i && sa.free1_id == SW'(i)) begin
        if (map_q[i] && !(alloc_ok && ns_q == SW'(i))) dbl = 1'b1;
        map_d[i] = 1'b1;
      end
    end

    if (sa.free0_i && 32'(sa.free0_id) >= NSTREAM) dbl = 1'b1;
    if (sa.free1_i && 32'(sa.free1_id) >= NSTREAM) dbl = 1'b1;

    ns_d = '0;
    for (int i = int'(NSTREAM) - 1; i >= 0; i--) begin
      if (map_d[i]) ns_d = SW'(i);
    end
    ns_v_d = |map_d;

    nfree_d = '0;
    for (int unsigned i = 0; i < NSTREAM; i++) begin
      nfree_d = nfree_d + 8'(map_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q       <= MapRst;
      ns_q        <= SW'(2);
      ns_v_q      <= 1'b1;
      nfree_q     <= 8'(NSTREAM - 2);
      err_dbl_q   <= 1'b0;
      err_empty_q <= 1'b0;
    end else begin
      map_q       <= map_d;
      ns_q        <= ns_d;
      ns_v_q      <= ns_v_d;
      nfree_q     <= nfree_d;
      err_dbl_q   <= err_dbl_q | dbl;
      err_empty_q <= err_empty_q | (sa.alloc_i & ~ns_v_q);
    end
  end

  assign sa.new_stream   = ns_q;
  assign sa.new_stream_v = ns_v_q;
  assign sa.nfree        = nfree_q;
  assign sa.err_dblfree  = err_dbl_q;
  assign sa.err_empty    = err_empty_q;

endmodule

// File: tb/tb_qupls4_stream_alloc.sv
// Directed bench for qupls4_stream_alloc with hand-computed expectations.
module tb_qupls4_stream_alloc;

  localparam int unsigned NSTREAM = 32;
  localparam int unsigned SW      = 7;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  qupls4_stream_alloc_if #(.SW(SW)) sa ();

  qupls4_stream_alloc #(
    .NSTREAM (NSTREAM),
    .SW      (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sa    (sa.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ns, input int v, input int nf,
                         input int edb, input int eem);
    chk({tag, ".new_stream"}, 32'(sa.new_stream), 32'(ns));
    chk({tag, ".new_stream_v"}, 32'(sa.new_stream_v), 32'(v));
    chk({tag, ".nfree"}, 32'(sa.nfree), 32'(nf));
    chk({tag, ".err_dblfree"}, 32'(sa.err_dblfree), 32'(edb));
    chk({tag, ".err_empty"}, 32'(sa.err_empty), 32'(eem));
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    sa.alloc_i  = 1'b0;
    sa.free0_i  = 1'b0;
    sa.free0_id = '0;
    sa.free1_i  = 1'b0;
    sa.free1_id = '0;
    repeat (3) step();
    chk_all("in_reset", 2, 1, 30, 0, 0);
    rst_n = 1'b1;
    step();
    step();
    chk_all("reset_idle", 2, 1, 30, 0, 0);

    // 30 back-to-back allocs present 2..31 in order.
    sa.alloc_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("burst_id%0d", k), 32'(sa.new_stream), 32'(k + 2));
      chk($sformatf("burst_nfree%0d", k), 32'(sa.nfree), 32'(30 - k));
      step();
    end
    chk_all("drained", 0, 0, 0, 0, 0);
    step();
    sa.alloc_i = 1'b0;
    chk_all("alloc_empty", 0, 0, 0, 0, 1);

    sa.free0_i  = 1'b1;
    sa.free0_id = SW'(17);
    step();
    sa.free0_i = 1'b0;
    chk_all("free17", 17, 1, 1, 0, 1);
    sa.free1_i  = 1'b1;
    sa.free1_id = SW'(5);
    step();
    sa.free1_i = 1'b0;
    chk_all("free5", 5, 1, 2, 0, 1);
    sa.free0_i  = 1'b1;
    sa.free0_id = SW'(4);
    step();
    chk_all("free4", 4, 1, 3, 0, 1);

    // Alloc and free of ID 4 together: the free wins, not a double free.
    sa.alloc_i = 1'b1;
    step();
    sa.alloc_i = 1'b0;
    sa.free0_i = 1'b0;
    chk_all("alloc_free_same", 4, 1, 3, 0, 1);

    sa.free0_i  = 1'b1;
    sa.free0_id = '0;
    step();
    sa.free0_i = 1'b0;
    chk_all("free_id0", 4, 1, 3, 0, 1);

    sa.free0_i  = 1'b1;
    sa.free0_id = SW'(9);
    sa.free1_i  = 1'b1;
    sa.free1_id = SW'(9);
    step();
    sa.free1_i = 1'b0;
    chk_all("free9_both", 4, 1, 4, 0, 1);
    step();
    sa.free0_i = 1'b0;
    chk_all("refree9", 4, 1, 4, 1, 1);

    sa.alloc_i = 1'b1;
    step();
    chk_all("alloc4", 5, 1, 3, 1, 1);

    // Reset mid-burst: outputs return immediately, without a clock edge.
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 2, 1, 30, 0, 0);
    step();
    sa.alloc_i = 1'b0;
    rst_n      = 1'b1;
    step();
    chk_all("post_reset", 2, 1, 30, 0, 0);
    sa.alloc_i = 1'b1;
    step();
    step();
    step();
    sa.alloc_i = 1'b0;
    chk_all("realloc3", 5, 1, 27, 0, 0);

    sa.free0_i  = 1'b1;
    sa.free0_id = SW'(1);
    step();
    sa.free0_i = 1'b0;
    chk_all("free_reset_stream", 1, 1, 28, 0, 0);
    sa.free1_i  = 1'b1;
    sa.free1_id = SW'(40);
    step();
    sa.free1_i = 1'b0;
    chk_all("free_out_of_range", 1, 1, 28, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
